// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FORCE = 1'b1
    } arb_state_e;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN_DEF   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    function automatic logic writes_reg(input logic we, input logic [REG_ADDR_W-1:0] rd);
        return we && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/wb_arb_starve_cnt.sv
// Starvation counter: counts denied NoC cycles and flags the cycle whose denial forces a grant.
module wb_arb_starve_cnt #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] SAT   = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt;

    // Saturates at MAX_WAIT so a stray increment can never wrap back below the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != SAT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign limit_hit = (cnt == LIMIT);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between writeback and NoC receive writes.
// Optional statistics counters are enabled with `define WB_ARB_STATS_EN.
//
// state | meaning
// IDLE  | writeback has priority, NoC uses idle slots, denials are counted
// FORCE | one-cycle pipeline stall, NoC is granted the port unconditionally
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 8,
    parameter int XLEN     = XLEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_we_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0]       wb_data_i,
    input  logic                  noc_valid_i,
    input  logic [REG_ADDR_W-1:0] noc_rd_i,
    input  logic [XLEN-1:0]       noc_data_i,
    output logic                  noc_ready_o,
    output logic                  stall_o,
    output logic                  rf_we_o,
    output logic [REG_ADDR_W-1:0] rf_addr_o,
`ifdef WB_ARB_STATS_EN
    output logic [XLEN-1:0]       rf_wdata_o,
    output logic [31:0]           noc_grant_cnt_o,
    output logic [15:0]           force_cnt_o
`else
    output logic [XLEN-1:0]       rf_wdata_o
`endif
);

    arb_state_e state, state_nxt;

    logic                  wb_use;
    logic                  ready_c;
    logic                  stall_c;
    logic                  we_c;
    logic [REG_ADDR_W-1:0] addr_c;
    logic [XLEN-1:0]       wdata_c;
    logic                  denied;
    logic                  handshake;
    logic                  limit_hit;

    assign wb_use    = writes_reg(wb_we_i, wb_rd_i);
    assign denied    = noc_valid_i & ~ready_c;
    assign handshake = noc_valid_i & ready_c;

    wb_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_starve_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       ((state == IDLE) & denied),
        .clr       (handshake | (state == FORCE)),
        .limit_hit (limit_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (denied && limit_hit) state_nxt = FORCE;
            FORCE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant mux. In FORCE the held writeback is dropped; the stall keeps it in M/WB for the next cycle.
    always_comb begin
        ready_c = 1'b0;
        stall_c = 1'b0;
        we_c    = 1'b0;
        addr_c  = '0;
        wdata_c = '0;
        case (state)
            IDLE: begin
                if (wb_use) begin
                    we_c    = 1'b1;
                    addr_c  = wb_rd_i;
                    wdata_c = wb_data_i;
                end else if (noc_valid_i) begin
                    ready_c = 1'b1;
                    we_c    = writes_reg(1'b1, noc_rd_i);
                    addr_c  = noc_rd_i;
                    wdata_c = noc_data_i;
                end
            end
            FORCE: begin
                stall_c = 1'b1;
                if (noc_valid_i) begin
                    ready_c = 1'b1;
                    we_c    = writes_reg(1'b1, noc_rd_i);
                    addr_c  = noc_rd_i;
                    wdata_c = noc_data_i;
                end
            end
            default: ;
        endcase
    end

    assign noc_ready_o = ready_c & rst_n;
    assign stall_o     = stall_c & rst_n;
    assign rf_we_o     = we_c & rst_n;
    assign rf_addr_o   = rst_n ? addr_c : '0;
    assign rf_wdata_o  = rst_n ? wdata_c : '0;

`ifdef WB_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            noc_grant_cnt_o <= '0;
            force_cnt_o     <= '0;
        end else begin
            if (handshake) noc_grant_cnt_o <= noc_grant_cnt_o + 32'd1;
            if (state == FORCE) force_cnt_o <= force_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter with default parameters (MAX_WAIT=4).
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_we_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        noc_valid_i;
    logic [4:0]  noc_rd_i;
    logic [31:0] noc_data_i;
    logic        noc_ready_o;
    logic        stall_o;
    logic        rf_we_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_wdata_o;
`ifdef WB_ARB_STATS_EN
    logic [31:0] noc_grant_cnt_o;
    logic [15:0] force_cnt_o;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_port_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_we_i     (wb_we_i),
        .wb_rd_i     (wb_rd_i),
        .wb_data_i   (wb_data_i),
        .noc_valid_i (noc_valid_i),
        .noc_rd_i    (noc_rd_i),
        .noc_data_i  (noc_data_i),
        .noc_ready_o (noc_ready_o),
        .stall_o     (stall_o),
        .rf_we_o     (rf_we_o),
        .rf_addr_o   (rf_addr_o),
`ifdef WB_ARB_STATS_EN
        .rf_wdata_o      (rf_wdata_o),
        .noc_grant_cnt_o (noc_grant_cnt_o),
        .force_cnt_o     (force_cnt_o)
`else
        .rf_wdata_o  (rf_wdata_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wwe, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic nv, input logic [4:0] nrd, input logic [31:0] nd);
        wb_we_i     = wwe;
        wb_rd_i     = wrd;
        wb_data_i   = wd;
        noc_valid_i = nv;
        noc_rd_i    = nrd;
        noc_data_i  = nd;
    endtask

    // Checks all port outputs at the negedge, then advances to just after the next posedge.
    task automatic cyc(input string tag, input logic rdy, input logic stl, input logic we,
                       input logic [4:0] addr, input logic [31:0] wd);
        @(negedge clk);
        chk({tag, ".ready"}, 32'(noc_ready_o), 32'(rdy));
        chk({tag, ".stall"}, 32'(stall_o), 32'(stl));
        chk({tag, ".we"},    32'(rf_we_o), 32'(we));
        if (we) begin
            chk({tag, ".addr"},  32'(rf_addr_o), 32'(addr));
            chk({tag, ".wdata"}, rf_wdata_o, wd);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd9, 32'h99);
        #12;
        chk("rst.ready", 32'(noc_ready_o), 32'd0);
        chk("rst.stall", 32'(stall_o), 32'd0);
        chk("rst.we",    32'(rf_we_o), 32'd0);
        chk("rst.addr",  32'(rf_addr_o), 32'd0);
        chk("rst.wdata", rf_wdata_o, 32'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc("quiet", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEADBEEF);
        cyc("idle_slot", 1'b1, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF);

        drive(1'b1, 5'd0, 32'h55, 1'b1, 5'd3, 32'h33);
        cyc("wb_x0", 1'b1, 1'b0, 1'b1, 5'd3, 32'h33);

        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h44);
        cyc("noc_x0", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);

        drive(1'b1, 5'd0, 32'h66, 1'b0, 5'd0, 32'h0);
        cyc("wb_only_x0", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);

        drive(1'b1, 5'd12, 32'h1234, 1'b0, 5'd0, 32'h0);
        cyc("wb_only", 1'b0, 1'b0, 1'b1, 5'd12, 32'h1234);

        // Starvation: four denials, then a forced grant, then the held writeback.
        drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd9, 32'h99);
        for (int i = 0; i < 4; i++) cyc($sformatf("starve_d%0d", i), 1'b0, 1'b0, 1'b1, 5'd5, 32'h11);
        cyc("starve_force", 1'b1, 1'b1, 1'b1, 5'd9, 32'h99);
        drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
        cyc("starve_after", 1'b0, 1'b0, 1'b1, 5'd5, 32'h11);

        // Recovery: two denials, a grant clears the count, a new request needs four fresh denials.
        drive(1'b1, 5'd5, 32'h22, 1'b1, 5'd10, 32'hA0);
        cyc("rec_d0", 1'b0, 1'b0, 1'b1, 5'd5, 32'h22);
        cyc("rec_d1", 1'b0, 1'b0, 1'b1, 5'd5, 32'h22);
        drive(1'b0, 5'd5, 32'h22, 1'b1, 5'd10, 32'hA0);
        cyc("rec_grant", 1'b1, 1'b0, 1'b1, 5'd10, 32'hA0);
        drive(1'b1, 5'd6, 32'h23, 1'b1, 5'd11, 32'hB0);
        for (int i = 0; i < 4; i++) cyc($sformatf("rec_n%0d", i), 1'b0, 1'b0, 1'b1, 5'd6, 32'h23);
        cyc("rec_force", 1'b1, 1'b1, 1'b1, 5'd11, 32'hB0);

        // Reset asserted during FORCE.
        drive(1'b1, 5'd5, 32'h11, 1'b1, 5'd9, 32'h99);
        for (int i = 0; i < 4; i++) cyc($sformatf("rf_d%0d", i), 1'b0, 1'b0, 1'b1, 5'd5, 32'h11);
        chk("rf_in_force.stall", 32'(stall_o), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rf_rst.stall", 32'(stall_o), 32'd0);
        chk("rf_rst.ready", 32'(noc_ready_o), 32'd0);
        chk("rf_rst.we",    32'(rf_we_o), 32'd0);
`ifdef WB_ARB_STATS_EN
        chk("rf_rst.force_cnt", 32'(force_cnt_o), 32'd0);
        chk("rf_rst.grant_cnt", noc_grant_cnt_o, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc($sformatf("rf_post%0d", i), 1'b0, 1'b0, 1'b1, 5'd5, 32'h11);
        cyc("rf_post3", 1'b0, 1'b0, 1'b1, 5'd5, 32'h11);
        cyc("rf_post_force", 1'b1, 1'b1, 1'b1, 5'd9, 32'h99);
`ifdef WB_ARB_STATS_EN
        chk("stats.force_cnt", 32'(force_cnt_o), 32'd1);
        chk("stats.grant_cnt", noc_grant_cnt_o, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
